// File: rtl/hazard_controller.sv
// Pipeline hazard controller: forwarding selects, stall/flush enables,
// memory wait tracking with sticky timeout and stall-cycle counter.
module hazard_controller #(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic [1:0]       ResultSrcE,
  input  logic             PCSrcE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             MemTimeout,
  output logic [CNT_W-1:0] StallCount
);

  localparam int WW = $clog2(MAX_WAIT + 1);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t            state_q, state_d;
  logic [WW-1:0]     wcnt_q, wcnt_d;
  logic              to_q;
  logic              to_hit;
  logic [CNT_W-1:0]  scnt_q;

  logic hit_am, hit_aw, hit_bm, hit_bw;
  logic lw_stall, mem_stall;

  assign hit_am = RegWriteM && RdM != 5'd0 && RdM == Rs1E;
  assign hit_aw = RegWriteW && RdW != 5'd0 && RdW == Rs1E;
  assign hit_bm = RegWriteM && RdM != 5'd0 && RdM == Rs2E;
  assign hit_bw = RegWriteW && RdW != 5'd0 && RdW == Rs2E;

  always_comb begin
    ForwardAE = 2'b00;
    priority case (1'b1)
      hit_am:  ForwardAE = 2'b10;
      hit_aw:  ForwardAE = 2'b01;
      default: ForwardAE = 2'b00;
    endcase
  end

  always_comb begin
    ForwardBE = 2'b00;
    priority case (1'b1)
      hit_bm:  ForwardBE = 2'b10;
      hit_bw:  ForwardBE = 2'b01;
      default: ForwardBE = 2'b00;
    endcase
  end

  assign lw_stall = ResultSrcE == 2'b01 && RdE != 5'd0 &&
                    (RdE == Rs1D || RdE == Rs2D);
  assign mem_stall = MemReqM && !MemReadyM;

  // Execute is frozen during a memory wait, so branch and
  // load-use actions wait for the release cycle.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (rst) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushW = 1'b1;
    end else if (mem_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else begin
      StallF = lw_stall;
      StallD = lw_stall;
      FlushE = lw_stall | PCSrcE;
      FlushD = PCSrcE;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (mem_stall) begin
          state_d = S_WAIT;
          wcnt_d  = WW'(1);
        end
      end
      S_WAIT: begin
        if (mem_stall) begin
          if (wcnt_q != WW'(MAX_WAIT))
            wcnt_d = wcnt_q + WW'(1);
        end else begin
          state_d = S_IDLE;
          wcnt_d  = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        wcnt_d  = '0;
      end
    endcase
  end

  // wcnt_d counts the current stall cycle, so the flag shows
  // in the very cycle the wait reaches MAX_WAIT.
  assign to_hit = !rst && mem_stall &&
                  wcnt_d == WW'(MAX_WAIT);
  assign MemTimeout = to_q | to_hit;
  assign StallCount = scnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      to_q    <= 1'b0;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      to_q    <= to_q | to_hit;
      if (StallF)
        scnt_q <= scnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: directed plan steps plus random cycles
// checked against a run-length based reference model.
module tb_hazard_controller;

  localparam int MW = 16;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic          RegWriteM, RegWriteW;
  logic [1:0]    ResultSrcE;
  logic          PCSrcE, MemReqM, MemReadyM;
  logic [1:0]    ForwardAE, ForwardBE;
  logic          StallF, StallD, StallE, StallM;
  logic          FlushD, FlushE, FlushW;
  logic          MemTimeout;
  logic [CW-1:0] StallCount;

  int vec  = 0;
  int miss = 0;
  int run  = 0;
  bit sticky = 1'b0;
  int scnt = 0;

  always #5 clk = ~clk;

  hazard_controller #(.MAX_WAIT(MW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD),
    .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .MemTimeout(MemTimeout), .StallCount(StallCount)
  );

  function automatic logic [1:0] fwd(input logic [4:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    assert (got === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, got, exp);
    end
  endtask

  task automatic idle();
    rst = 0; Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0;
    RdE = 0; RdM = 0; RdW = 0; RegWriteM = 0;
    RegWriteW = 0; ResultSrcE = 0; PCSrcE = 0;
    MemReqM = 0; MemReadyM = 0;
  endtask

  task automatic cyc();
    logic [1:0] fa, fb;
    bit lw, ms, sf, se, fd, fe, fw, to;
    int rc;
    fa = fwd(Rs1E);
    fb = fwd(Rs2E);
    lw = ResultSrcE == 2'b01 && RdE != 0 &&
         (RdE == Rs1D || RdE == Rs2D);
    ms = MemReqM && !MemReadyM;
    if (rst) begin
      sf = 0; se = 0; fd = 1; fe = 1; fw = 1;
    end else if (ms) begin
      sf = 1; se = 1; fd = 0; fe = 0; fw = 1;
    end else begin
      sf = lw; se = 0; fd = PCSrcE;
      fe = lw | PCSrcE; fw = 0;
    end
    rc = (!rst && ms) ? run + 1 : 0;
    to = rst ? sticky : (sticky || rc >= MW);
    #2;
    chk("ForwardAE", 32'(ForwardAE), 32'(fa));
    chk("ForwardBE", 32'(ForwardBE), 32'(fb));
    chk("StallF", 32'(StallF), 32'(sf));
    chk("StallD", 32'(StallD), 32'(sf));
    chk("StallE", 32'(StallE), 32'(se));
    chk("StallM", 32'(StallM), 32'(se));
    chk("FlushD", 32'(FlushD), 32'(fd));
    chk("FlushE", 32'(FlushE), 32'(fe));
    chk("FlushW", 32'(FlushW), 32'(fw));
    chk("MemTimeout", 32'(MemTimeout), 32'(to));
    chk("StallCount", 32'(StallCount), 32'(scnt));
    vec++;
    @(posedge clk);
    if (rst) begin
      sticky = 0; scnt = 0; run = 0;
    end else begin
      sticky = to;
      run = rc;
      if (sf) scnt = (scnt + 1) % (1 << CW);
    end
    #1;
  endtask

  initial begin
    idle();
    rst = 1;
    @(posedge clk); #1;
    cyc();
    rst = 0;
    cyc();

    RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1;
    Rs1E = 5; Rs2E = 5;
    cyc();
    RegWriteM = 0;
    cyc();
    RdM = 0; RdW = 0; Rs1E = 0;
    cyc();
    idle();

    ResultSrcE = 2'b01; RdE = 7; Rs2D = 7;
    cyc();
    ResultSrcE = 2'b00;
    cyc();
    idle();

    PCSrcE = 1;
    cyc();
    ResultSrcE = 2'b01; RdE = 7; Rs1D = 7;
    cyc();
    idle();

    PCSrcE = 1; MemReqM = 1;
    repeat (3) cyc();
    MemReadyM = 1;
    cyc();
    idle();
    cyc();

    MemReqM = 1;
    repeat (20) cyc();
    MemReadyM = 1;
    cyc();
    idle();
    repeat (2) cyc();
    rst = 1;
    cyc();
    rst = 0;
    cyc();

    MemReqM = 1;
    cyc();
    rst = 1;
    cyc();
    rst = 0;
    repeat (17) cyc();
    idle();
    cyc();

    for (int i = 0; i < 1500; i++) begin
      rst        = ($urandom_range(399) == 0);
      Rs1D       = 5'($urandom_range(3));
      Rs2D       = 5'($urandom_range(3));
      Rs1E       = 5'($urandom_range(3));
      Rs2E       = 5'($urandom_range(3));
      RdE        = 5'($urandom_range(3));
      RdM        = 5'($urandom_range(3));
      RdW        = 5'($urandom_range(3));
      RegWriteM  = 1'($urandom);
      RegWriteW  = 1'($urandom);
      ResultSrcE = 2'($urandom);
      PCSrcE     = ($urandom_range(3) == 0);
      MemReqM    = ($urandom_range(2) != 0);
      MemReadyM  = ($urandom_range(3) == 0);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vec, miss);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview: Central hazard and sequencing controller for the 5-stage RISC-V pipeline. It drives the stall and flush enables of the F/D, D/E, E/M and M/W pipeline registers, and selects the forwarding muxes in Execute. It also tracks variable-latency data-memory accesses in Memory with a wait FSM, a timeout detector and a stall-cycle counter.

Parameters:
MAX_WAIT, 16, maximum Memory-stage wait cycles before timeout is flagged
CNT_W, 32, width of stall-cycle performance counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
Rs1D  in  5  source reg 1 in Decode
Rs2D  in  5  source reg 2 in Decode
Rs1E  in  5  source reg 1 in Execute
Rs2E  in  5  source reg 2 in Execute
RdE  in  5  dest reg in Execute
RdM  in  5  dest reg in Memory
RdW  in  5  dest reg in Writeback
RegWriteM  in  1  Memory-stage writes register
RegWriteW  in  1  Writeback-stage writes register
ResultSrcE  in  2  Execute result select; 2'b01 = load
PCSrcE  in  1  taken branch/jump resolved in Execute
MemReqM  in  1  load/store active in Memory
MemReadyM  in  1  data memory completes access this cycle
ForwardAE  out  2  operand A select: 00 regfile, 01 Writeback result, 10 ALUResultM
ForwardBE  out  2  operand B select, same encoding
StallF  out  1  hold PC
StallD  out  1  hold F/D register
StallE  out  1  hold D/E register
StallM  out  1  hold E/M register
FlushD  out  1  clear F/D register
FlushE  out  1  clear D/E register
FlushW  out  1  clear M/W register (bubble)
MemTimeout  out  1  sticky: memory wait exceeded MAX_WAIT
StallCount  out  CNT_W  total cycles with StallF=1

Behaviour:
- Forwarding (combinational): ForwardAE=10 if RegWriteM & RdM!=0 & RdM==Rs1E; else 01 if RegWriteW & RdW!=0 & RdW==Rs1E; else 00. M has priority over W. ForwardBE is identical using Rs2E. x0 is never forwarded.
- Load-use: lwStall = (ResultSrcE==01) & RdE!=0 & (RdE==Rs1D | RdE==Rs2D).
- memStall = MemReqM & ~MemReadyM.
- Priority, highest first:
  - rst: FlushD=FlushE=FlushW=1, all stalls 0.
  - memStall: StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0. Branch and load-use actions are deferred because Execute is frozen; they act in the release cycle.
  - Otherwise: StallF=StallD=lwStall; FlushE=lwStall|PCSrcE; FlushD=PCSrcE; StallE=StallM=FlushW=0.
- Simultaneous lwStall and PCSrcE (no memStall): FlushD=1, FlushE=1, StallF=StallD=1. The fetch redirect still takes effect because the PC mux loads the branch target. The flushed D holds no valid load-use pair.
- Wait FSM (registered):
  - State IDLE -> WAIT when memStall; wait counter loads 1.
  - WAIT: counter increments each cycle while memStall, saturating at MAX_WAIT. When counter==MAX_WAIT with memStall still high, MemTimeout sets. WAIT -> IDLE when MemReadyM=1 or MemReqM=0; counter clears.
  - Stall outputs derive from memStall directly, so stall release is the same cycle MemReadyM rises (zero-latency release).
  - MemTimeout is sticky until rst. It does not alter stall behaviour.
- StallCount increments by 1 on every cycle with StallF=1. It wraps modulo 2^CNT_W.
- Reset: FSM=IDLE, wait counter=0, MemTimeout=0, StallCount=0 on the next clk edge. Reset mid-WAIT aborts the wait immediately. Forward outputs are combinational on inputs and are unaffected by rst.

Test Plan:
- RAW forwarding: RdM=5,RegWriteM=1,RdW=5,RegWriteW=1,Rs1E=5,Rs2E=5 -> ForwardAE=ForwardBE=10. Then RegWriteM=0 -> both 01. Then RdM=RdW=0, Rs1E=0 -> 00.
- Load-use: ResultSrcE=01,RdE=7,Rs2D=7 for 1 cycle -> StallF=StallD=FlushE=1, FlushD=0. StallCount 0->1. Next cycle with ResultSrcE=00 -> all stalls 0.
- Branch flush: PCSrcE=1 alone -> FlushD=FlushE=1, stalls 0. PCSrcE=1 with lwStall condition -> FlushD=FlushE=StallF=StallD=1.
- Memory wait: MemReqM=1, MemReadyM=0 for 3 cycles, then MemReadyM=1 -> StallF/D/E/M=FlushW=1 for exactly 3 cycles, release on cycle 4. PCSrcE=1 held throughout -> FlushD=0 during wait, FlushD=1 on the release cycle. StallCount=3. MemTimeout=0.
- Timeout: MAX_WAIT=16, MemReqM=1, MemReadyM=0 for 20 cycles -> MemTimeout rises on the 16th stall cycle and stays 1 after ready. Then rst for 1 cycle -> MemTimeout=0, StallCount=0, FSM IDLE.
- Reset mid-wait: rst asserted on 2nd wait cycle -> FlushD=FlushE=FlushW=1, stalls 0 during rst. After rst with MemReqM=1, MemReadyM=0, the wait counter restarts at 1.
